// File: rtl/mem_io_bridge.sv
// rtl/mem_io_bridge.sv - SLC-3 memory/IO bridge: SRAM access FSM plus switch/hex I/O port (optional MEMIO_EXTRA_WAIT_EN adds ACC3 wait state)
module mem_io_bridge #(
    parameter logic [15:0] IO_ADDR = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ready,
    input  logic [15:0] S,
    output logic [15:0] hex_reg,
    output logic [19:0] ADDR,
    inout  wire  [15:0] Data,
    output logic        CE,
    output logic        UB,
    output logic        LB,
    output logic        OE,
    output logic        WE
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC1 = 3'd1,
        ACC2 = 3'd2,
`ifdef MEMIO_EXTRA_WAIT_EN
        ACC3 = 3'd3,
`endif
        DONE = 3'd4
    } state_t;

    // Read data is sampled on the edge that leaves this state.
`ifdef MEMIO_EXTRA_WAIT_EN
    localparam state_t LAST_ACC = ACC3;
`else
    localparam state_t LAST_ACC = ACC2;
`endif

    state_t      state;
    state_t      state_next;
    logic        we_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        in_acc;
    logic        drive_data;
    logic        is_io;
    logic        accept;

    assign is_io  = (cpu_addr == IO_ADDR);
    assign accept = (state == IDLE) && cpu_req;

    // State register; reset aborts any access in flight.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and strobe decode; strobes stay inactive outside ACC states.
    always_comb begin
        state_next = state;
        cpu_ready  = 1'b0;
        in_acc     = 1'b0;
        CE         = 1'b1;
        UB         = 1'b1;
        LB         = 1'b1;
        OE         = 1'b1;
        WE         = 1'b1;
        drive_data = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    state_next = is_io ? DONE : ACC1;
                end
            end
            ACC1: begin
                in_acc     = 1'b1;
                state_next = ACC2;
            end
            ACC2: begin
                in_acc = 1'b1;
`ifdef MEMIO_EXTRA_WAIT_EN
                state_next = ACC3;
`else
                state_next = DONE;
`endif
            end
`ifdef MEMIO_EXTRA_WAIT_EN
            ACC3: begin
                in_acc     = 1'b1;
                state_next = DONE;
            end
`endif
            DONE: begin
                cpu_ready  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (in_acc) begin
            CE         = 1'b0;
            UB         = 1'b0;
            LB         = 1'b0;
            OE         = we_q;
            WE         = ~we_q;
            drive_data = we_q;
        end
    end

    assign Data = drive_data ? wdata_q : 16'hzzzz;
    assign ADDR = {4'h0, addr_q};

    // Request capture, I/O port registers and SRAM read-data capture.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            we_q      <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            cpu_rdata <= 16'h0000;
            hex_reg   <= 16'h0000;
        end else if (accept) begin
            we_q    <= cpu_we;
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            if (is_io) begin
                if (cpu_we) begin
                    hex_reg <= cpu_wdata;
                end else begin
                    cpu_rdata <= S;
                end
            end
        end else if ((state == LAST_ACC) && !we_q) begin
            cpu_rdata <= Data;
        end
    end

endmodule

// File: tb/tb_mem_io_bridge.sv
// tb/tb_mem_io_bridge.sv - randomized self-checking bench for mem_io_bridge with SRAM model and reference model
module tb_mem_io_bridge;

`ifdef MEMIO_EXTRA_WAIT_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [15:0] cpu_wdata = 16'h0000;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic [15:0] S = 16'h0000;
    logic [15:0] hex_reg;
    logic [19:0] ADDR;
    wire  [15:0] Data;
    logic        CE, UB, LB, OE, WE;

    int errors = 0;
    int checks = 0;

    mem_io_bridge #(.IO_ADDR(16'hFFFF)) dut (
        .Clk(Clk), .Reset(Reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .S(S), .hex_reg(hex_reg), .ADDR(ADDR),
        .Data(Data), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE)
    );

    always #5 Clk = ~Clk;

    // Asynchronous SRAM model: drives during read strobes, stores on write strobes.
    logic [15:0] sram_mem [0:65535];
    assign Data = (!CE && !OE && WE) ? sram_mem[ADDR[15:0]] : 16'hzzzz;
    always @(posedge Clk) begin
        if (!CE && !WE) sram_mem[ADDR[15:0]] <= Data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: transaction-level timing from accept edge and latency.
    logic [15:0] ref_mem [0:65535];
    int          cyc = 0;
    int          next_free = 0;
    int          acc_edge = -10;
    int          ready_edge = -10;
    bit          m_io = 1'b1;
    bit          m_we = 1'b0;
    logic [15:0] m_addr = 16'h0000;
    logic [15:0] m_wdata = 16'h0000;
    logic [15:0] m_rdval = 16'h0000;
    logic [15:0] exp_rdata = 16'h0000;
    logic [15:0] exp_hex = 16'h0000;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cyc = 0; next_free = 0; acc_edge = -10; ready_edge = -10;
            m_io = 1'b1; exp_rdata = 16'h0000; exp_hex = 16'h0000;
        end else begin
            cyc++;
            if (!m_io && !m_we && cyc == ready_edge) exp_rdata = m_rdval;
            if (cpu_req && cyc >= next_free) begin
                m_io = (cpu_addr == 16'hFFFF);
                m_we = cpu_we;
                m_addr = cpu_addr;
                m_wdata = cpu_wdata;
                acc_edge = cyc;
                ready_edge = cyc + (m_io ? 1 : LAT) - 1;
                next_free = ready_edge + 2;
                if (m_io) begin
                    if (cpu_we) exp_hex = cpu_wdata;
                    else exp_rdata = S;
                end else if (cpu_we) begin
                    ref_mem[cpu_addr] = cpu_wdata;
                end else begin
                    m_rdval = ref_mem[cpu_addr];
                end
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge Clk) begin
        bit active;
        active = !m_io && cyc >= acc_edge && cyc <= ready_edge - 1;
        chk("cpu_ready", cpu_ready, (cyc == ready_edge) ? 1 : 0);
        chk("cpu_rdata", cpu_rdata, exp_rdata);
        chk("hex_reg", hex_reg, exp_hex);
        chk("CE", CE, active ? 0 : 1);
        chk("UB_LB", {UB, LB}, active ? 0 : 3);
        chk("OE", OE, (active && !m_we) ? 0 : 1);
        chk("WE", WE, (active && m_we) ? 0 : 1);
        if (active) chk("ADDR", ADDR, {4'h0, m_addr});
        if (active && m_we) chk("Data_write", Data, m_wdata);
    end

    task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                          output int lat, output int we_low, output int ce_low);
        @(negedge Clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        @(posedge Clk);
        #1 cpu_req = 1'b0;
        lat = 0; we_low = 0; ce_low = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            lat++;
            if (!WE) we_low++;
            if (!CE) ce_low++;
            if (cpu_ready) break;
        end
        if (!cpu_ready) begin
            errors++;
            $display("FAIL ready_timeout: got no cpu_ready required within 20 cycles");
        end
    endtask

    initial begin
        int lat, wl, cl, nready;
        for (int i = 0; i < 65536; i++) begin
            sram_mem[i] = 16'h0000;
            ref_mem[i]  = 16'h0000;
        end
        #2 Reset = 1'b1;
        #1;
        chk("rst_ready", cpu_ready, 0);
        chk("rst_rdata", cpu_rdata, 16'h0000);
        chk("rst_hex", hex_reg, 16'h0000);
        chk("rst_addr", ADDR, 20'h0);
        chk("rst_strobes", {CE, UB, LB, OE, WE}, 5'b11111);
        @(negedge Clk); @(negedge Clk);
        Reset = 1'b0;

        // I/O write to hex display
        do_req(1'b1, 16'hFFFF, 16'hA0A0, lat, wl, cl);
        chk("io_wr_lat", lat, 1);
        chk("io_wr_hex", hex_reg, 16'hA0A0);
        chk("io_wr_ce", cl, 0);

        // I/O read of switches; later switch changes must not leak through
        S = 16'h0003;
        do_req(1'b0, 16'hFFFF, 16'h0000, lat, wl, cl);
        chk("io_rd_lat", lat, 1);
        S = 16'hFFFF;
        repeat (3) @(negedge Clk);
        chk("io_rd_data", cpu_rdata, 16'h0003);
        chk("io_rd_ce", cl, 0);

        // SRAM write then read back
        do_req(1'b1, 16'h0005, 16'h1234, lat, wl, cl);
        chk("sram_wr_lat", lat, LAT);
        chk("sram_wr_we_low", wl, LAT - 1);
        do_req(1'b0, 16'h0005, 16'h0000, lat, wl, cl);
        chk("sram_rd_lat", lat, LAT);
        chk("sram_rd_data", cpu_rdata, 16'h1234);
        chk("sram_rd_we_low", wl, 0);

        // Reset asserted during ACC1 of a write aborts it immediately
        @(negedge Clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 16'hBEEF;
        @(posedge Clk);
        #1 cpu_req = 1'b0;
        chk("acc1_we_low", WE, 0);
        #2 Reset = 1'b1;
        #1;
        chk("abort_we", WE, 1);
        chk("abort_ce", CE, 1);
        chk("abort_ready", cpu_ready, 0);
        chk("abort_hex", hex_reg, 16'h0000);
        @(negedge Clk); @(negedge Clk);
        Reset = 1'b0;
        nready = 0;
        repeat (6) begin
            @(negedge Clk);
            if (cpu_ready) nready++;
        end
        chk("abort_no_ready", nready, 0);

        // cpu_req held high for 8 back-to-back reads of address 0
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0000;
        nready = 0;
        repeat (8 * (LAT + 1)) begin
            @(negedge Clk);
            if (cpu_ready) nready++;
        end
        cpu_req = 1'b0;
        chk("held_req_readies", nready, 8);
        repeat (LAT + 2) @(negedge Clk);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            @(negedge Clk);
            cpu_req = 1'($urandom_range(0, 1));
            cpu_we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                8: cpu_addr = 16'hFFFE;
                9: cpu_addr = 16'hFFFF;
                default: cpu_addr = 16'($urandom_range(0, 7));
            endcase
            cpu_wdata = 16'($urandom);
            S = 16'($urandom);
        end
        @(negedge Clk);
        cpu_req = 1'b0;
        repeat (LAT + 3) @(negedge Clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running required finish before 500000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_io_bridge.md
MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

Interface
REQ-001 Parameter IO_ADDR, default 16'hFFFF: CPU address mapped to the switch/hex I/O port.
REQ-002 Clk  in  1  single system clock; all state changes on rising edge.
REQ-003 Reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 cpu_req  in  1  access request from SLC-3 datapath.
REQ-005 cpu_we  in  1  1 = write, 0 = read.
REQ-006 cpu_addr  in  16  word address.
REQ-007 cpu_wdata  in  16  write data (MDR contents).
REQ-008 cpu_rdata  out  16  read data to MDR; holds the last completed read value.
REQ-009 cpu_ready  out  1  one-cycle completion pulse.
REQ-010 S  in  16  board switches.
REQ-011 hex_reg  out  16  value shown on HEX displays.
REQ-012 ADDR  out  20  SRAM address = {4'h0, cpu_addr captured}.
REQ-013 Data  inout  16  SRAM data bus.
REQ-014 CE, UB, LB, OE, WE  out  1 each  SRAM strobes, active-low.

Function
REQ-015 FSM states: IDLE, ACC1, ACC2, [ACC3 when configured], DONE.
REQ-016 In IDLE, cpu_req=1 is accepted on the rising edge; cpu_we, cpu_addr and cpu_wdata are captured on that edge.
REQ-017 cpu_req is ignored in every state other than IDLE; the captured values are used for the entire access.
REQ-018 I/O path, captured address == IO_ADDR: no SRAM cycle; the FSM goes IDLE->DONE.
REQ-019 I/O read: cpu_rdata loads S on the accept edge.
REQ-020 I/O write: hex_reg loads cpu_wdata on the accept edge.
REQ-021 I/O completion: cpu_ready=1 in the cycle after acceptance.
REQ-022 SRAM path: IDLE->ACC1->ACC2->DONE->IDLE, giving cpu_ready=1 three cycles after the accept edge.
REQ-023 During ACC states: CE=UB=LB=0.
REQ-024 During ACC states of a read: OE=0, WE=1, Data=Z.
REQ-025 During ACC states of a write: OE=1, WE=0, Data driven with the captured wdata.
REQ-026 SRAM read: cpu_rdata captures Data on the edge leaving the final ACC state.
REQ-027 In IDLE and DONE: all strobes = 1, Data = Z; Data is never driven outside write ACC states.
REQ-028 cpu_ready is high only in DONE, for exactly one cycle.
REQ-029 DONE always returns to IDLE; back-to-back requests therefore have a minimum spacing of 1 idle cycle.
REQ-030 Requests to IO_ADDR never touch SRAM strobes; all other addresses, including IO_ADDR-1 and 16'h0000, go to SRAM.
REQ-031 An I/O read of S samples S on the accept edge only; later changes to S do not alter cpu_rdata.

Reset
REQ-032 While Reset=1, independent of Clk: FSM=IDLE, cpu_ready=0, cpu_rdata=16'h0000, hex_reg=16'h0000, ADDR=0, strobes=1, Data=Z.
REQ-033 Reset asserted mid-access aborts the access: no cpu_ready is issued, and a partial write may or may not land in SRAM.
REQ-034 After Reset deasserts, the first rising edge with cpu_req=1 is accepted normally.

Configuration
REQ-035 Macro MEMIO_EXTRA_WAIT_EN defined: ACC3 is inserted after ACC2 with identical strobes, giving SRAM latency = 4 cycles accept->ready, and read data sampled leaving ACC3.
REQ-036 Macro MEMIO_EXTRA_WAIT_EN undefined: ACC3 does not exist and SRAM latency = 3 cycles; the I/O path latency is 1 cycle in both builds.

Verification
REQ-037 Reset pulse during SRAM write ACC1 -> WE returns to 1 and Data to Z immediately, no cpu_ready, hex_reg=0000.
REQ-038 Write x1234 to x0005, then read x0005 using a bench SRAM model -> WE low exactly 2 cycles; read cpu_rdata=x1234; cpu_ready 3 cycles after each accept (4 cycles with MEMIO_EXTRA_WAIT_EN).
REQ-039 S=x0003, read xFFFF, then S=xFFFF with no new request -> cpu_rdata=x0003, ready 1 cycle after accept, CE stays 1.
REQ-040 Write xA0A0 to xFFFF -> hex_reg=xA0A0 on the accept edge; no SRAM strobe toggles.
REQ-041 Hold cpu_req=1 continuously for 8 reads of x0000 -> a new access is accepted only in IDLE, exactly one cpu_ready per access, Data never driven.
